// File: rtl/systolic_write_out.sv
// De-skews anti-diagonal wavefronts from the systolic array into row-aligned
// SRAM writes on a head (newer tile) and tail (older tile) port, banks round-robin.
// Optional lane saturation and sticky sat_flag: define WRITE_OUT_SAT_EN.
module systolic_write_out #(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ACC_DATA_WIDTH    = 24,
  parameter int NUM_BANKS         = 3,
  parameter int ADDR_WIDTH        = 6,
  parameter int MAX_TILES         = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [$clog2(MAX_TILES+1)-1:0]            num_tiles,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ARRAY_SIZE*ACC_DATA_WIDTH-1:0]      in_data,
  output logic                                      head_wen_n,
  output logic                                      tail_wen_n,
  output logic [$clog2(NUM_BANKS)-1:0]              head_bank,
  output logic [$clog2(NUM_BANKS)-1:0]              tail_bank,
  output logic [ADDR_WIDTH-1:0]                     head_addr,
  output logic [ADDR_WIDTH-1:0]                     tail_addr,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   head_wdata,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   tail_wdata,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      sat_flag
);

  localparam int N  = ARRAY_SIZE;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int AW = ACC_DATA_WIDTH;
  localparam int TW = $clog2(MAX_TILES+1);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW-1:0]         D_LAST     = DW'(N-1);
  localparam logic [DW-1:0]         D_PEN      = DW'(N-2);
  localparam logic [BW-1:0]         BANK_LAST  = BW'(NUM_BANKS-1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(2*N-1);
  localparam logic [ADDR_WIDTH-1:0] TAIL_OFS   = ADDR_WIDTH'(N);
  localparam logic signed [AW-1:0]  SAT_MAX    = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0]  SAT_MIN    = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [TW-1:0]         t_total, t_cnt;
  logic [DW-1:0]         d_cnt;
  logic [BW-1:0]         hb_q, tb_q;
  logic [ADDR_WIDTH-1:0] hbase_q, tbase_q;
  logic                  accept, d_wrap, last_run, last_drain, head_en, tail_en, job_start;
  int unsigned           d_int;
  logic [N*OW-1:0]       head_word, tail_word;

  function automatic logic [OW-1:0] conv_lane(input logic signed [AW-1:0] v);
`ifdef WRITE_OUT_SAT_EN
    if (v > SAT_MAX)      return SAT_MAX[OW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    else                  return v[OW-1:0];
`else
    return v[OW-1:0];
`endif
  endfunction

  assign accept     = in_valid & in_ready;
  assign job_start  = (state_q == IDLE) && start;
  assign d_wrap     = (d_cnt == D_LAST);
  assign last_run   = (t_cnt == t_total - TW'(1)) && d_wrap;
  assign last_drain = (d_cnt == D_PEN);
  assign head_en    = (state_q == RUN);
  assign tail_en    = (t_cnt != '0) && !d_wrap;
  assign d_int      = 32'(d_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_tiles == '0) ? DONE : RUN;
      RUN:     if (accept && last_run) state_d = (N > 1) ? DRAIN : DONE;
      DRAIN:   if (accept && last_drain) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN) || (state_q == DRAIN);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  // Tile/row tracked incrementally; bank and address base ride along so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_total <= '0;
      t_cnt   <= '0;
      d_cnt   <= '0;
      hb_q    <= '0;
      tb_q    <= '0;
      hbase_q <= '0;
      tbase_q <= '0;
    end else if (job_start) begin
      t_total <= num_tiles;
      t_cnt   <= '0;
      d_cnt   <= '0;
      hb_q    <= '0;
      tb_q    <= '0;
      hbase_q <= '0;
      tbase_q <= '0;
    end else if (accept) begin
      if (d_wrap) begin
        d_cnt   <= '0;
        t_cnt   <= t_cnt + TW'(1);
        tb_q    <= hb_q;
        tbase_q <= hbase_q;
        if (hb_q == BANK_LAST) begin
          hb_q    <= '0;
          hbase_q <= hbase_q + ROW_STRIDE;
        end else begin
          hb_q <= hb_q + BW'(1);
        end
      end else begin
        d_cnt <= d_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    head_word = '0;
    tail_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i <= d_int)
        head_word[(N-1-i)*OW +: OW] = conv_lane(in_data[i*AW +: AW]);
      if (i + 1 + d_int < N)
        tail_word[(N-1-i)*OW +: OW] = conv_lane(in_data[(i+1+d_int)*AW +: AW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_wen_n <= 1'b1;
      tail_wen_n <= 1'b1;
      head_bank  <= '0;
      tail_bank  <= '0;
      head_addr  <= '0;
      tail_addr  <= '0;
      head_wdata <= '0;
      tail_wdata <= '0;
    end else begin
      head_wen_n <= !(accept && head_en);
      tail_wen_n <= !(accept && tail_en);
      head_bank  <= (accept && head_en) ? hb_q : '0;
      tail_bank  <= (accept && tail_en) ? tb_q : '0;
      head_addr  <= (accept && head_en) ? hbase_q + ADDR_WIDTH'(d_cnt) : '0;
      tail_addr  <= (accept && tail_en) ? tbase_q + ADDR_WIDTH'(d_cnt) + TAIL_OFS : '0;
      head_wdata <= (accept && head_en) ? head_word : '0;
      tail_wdata <= (accept && tail_en) ? tail_word : '0;
    end
  end

`ifdef WRITE_OUT_SAT_EN
  logic head_clip, tail_clip;

  // Only lanes that land in a written slot may raise the flag.
  always_comb begin
    head_clip = 1'b0;
    tail_clip = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i <= d_int &&
          ($signed(in_data[i*AW +: AW]) > SAT_MAX || $signed(in_data[i*AW +: AW]) < SAT_MIN))
        head_clip = 1'b1;
      if (i + 1 + d_int < N &&
          ($signed(in_data[(i+1+d_int)*AW +: AW]) > SAT_MAX ||
           $signed(in_data[(i+1+d_int)*AW +: AW]) < SAT_MIN))
        tail_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (job_start)
      sat_flag <= 1'b0;
    else if (accept && ((head_en && head_clip) || (tail_en && tail_clip)))
      sat_flag <= 1'b1;
  end
`else
  logic unused_in_hi;
  assign unused_in_hi = ^in_data;
  assign sat_flag     = 1'b0;
`endif

endmodule

// File: doc/systolic_write_out.md
Name: systolic_write_out

Overview:
- Parametrised successor of the diagonal write-out stage.
- Accepts a continuous stream of skewed anti-diagonal wavefronts from the systolic array. Each wavefront carries lanes of two overlapping tiles.
- De-skews each wavefront into row-aligned SRAM words and writes them through two write ports (head = newer tile, tail = older tile).
- Tile-to-bank mapping is round-robin over NUM_BANKS banks. Job length is programmable per start; backpressure uses a valid/ready handshake.

Parameters:
- ARRAY_SIZE, 8, lanes per wavefront (N).
- OUTPUT_DATA_WIDTH, 16, stored lane width.
- ACC_DATA_WIDTH, 24, input lane width (must be >= OUTPUT_DATA_WIDTH).
- NUM_BANKS, 3, SRAM banks written round-robin (must be >= 2).
- ADDR_WIDTH, 6, SRAM address width.
- MAX_TILES, 16, upper bound for num_tiles; sets counter widths.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle job start pulse; ignored unless IDLE
- num_tiles  input  clog2(MAX_TILES+1)  tiles in job, sampled on start; 0 means done next cycle
- in_valid  input  1  wavefront valid
- in_ready  output  1  wavefront accepted when in_valid & in_ready
- in_data  input  ARRAY_SIZE*ACC_DATA_WIDTH  lane j at [j*ACC_DATA_WIDTH +: ACC_DATA_WIDTH], signed
- head_wen_n / tail_wen_n  output  1 each  active-low write enable
- head_bank / tail_bank  output  clog2(NUM_BANKS) each  target bank
- head_addr / tail_addr  output  ADDR_WIDTH each  target address
- head_wdata / tail_wdata  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH each  de-skewed word
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse after final write is issued
- sat_flag  output  1  sticky saturation indicator, see Optional Feature

Behaviour:
- Reset (async, immediate):
  - state = IDLE, all counters 0.
  - wen_n = 1; bank, addr, wdata = 0.
  - in_ready, busy, done, sat_flag = 0.
- FSM:
  - IDLE: on start with num_tiles > 0, latch T = num_tiles, clear counters, clear sat_flag, go RUN. On start with T = 0, go DONE.
  - RUN: in_ready = 1. Each accepted beat advances global wavefront g. When g = T*N-1 is accepted, go DRAIN if N > 1, else DONE.
  - DRAIN: in_ready = 1. Accepts the final N-1 wavefronts (g = T*N .. T*N+N-2). After the last beat, go DONE.
  - DONE: done = 1 for one cycle, then IDLE.
  - busy = 1 in RUN, DRAIN and DONE.
- Wavefront decode at accepted g: t = g div N, d = g mod N. Maintain these with counters, not a divider.
- Head write (tile t, local row d), only when t < T:
  - slot (N-1-i) = lane i for i <= d; other slots = 0.
  - bank = t mod NUM_BANKS.
  - addr = (t div NUM_BANKS)*(2N-1) + d.
- Tail write (tile t-1, local row d+N), only when t >= 1 and d < N-1:
  - slot (N-1-i) = lane i+1+d for i < N-1-d; other slots = 0.
  - bank = (t-1) mod NUM_BANKS.
  - addr = ((t-1) div NUM_BANKS)*(2N-1) + d + N.
- Row d = N-1 of the tail is never written; local rows per tile are 0..2N-2. This matches the existing layout.
- Lane conversion ACC_DATA_WIDTH -> OUTPUT_DATA_WIDTH: see Optional Feature.
- Latency: all write outputs are registered, 1 cycle after the accepting edge.
- Cycles without an accepted beat: both wen_n = 1, wdata/addr/bank = 0.
- start during RUN, DRAIN or DONE: ignored.
- in_valid in IDLE or DONE: not accepted (in_ready = 0).
- Reset mid-job: all pending writes are dropped; no done pulse.
- Address overflow of ADDR_WIDTH: wraps modulo 2^ADDR_WIDTH. Sizing is the integrator's responsibility.

Optional Feature:
- Macro: WRITE_OUT_SAT_EN.
- Defined:
  - Each lane saturates to the signed OUTPUT_DATA_WIDTH range, e.g. 16-bit: max 32767, min -32768.
  - sat_flag sets (sticky) in the cycle any written lane clips. It clears on start and on reset.
  - Zero-filled slots never set sat_flag.
- Undefined:
  - Lanes are truncated to their low OUTPUT_DATA_WIDTH bits.
  - sat_flag is tied 0.

Test Plan:
- N=4, T=1, lanes = 10*g+j, in_valid held high:
  - g=0: head addr 0, bank 0, wdata slots {3..0} = {0,0,0,0} with slot3 = 0.
  - g=2: head addr 2, slots 3..1 = {20,21,22}, slot0 = 0.
  - g=4..6 (DRAIN): tail addr 4..6; at g=4 slots 3..1 = {41,42,43}.
  - done pulses one cycle after the g=6 write is issued; total 7 beats.
- N=4, T=4, NUM_BANKS=3:
  - At g=9 (t=2, d=1): head bank 2, addr 1; tail bank 1, addr 5.
  - Tile 3: bank 0, addr base 7.
  - Both ports write in the same cycle.
- Random in_valid gaps, T=2:
  - Write sequence is identical to the gap-free run, shifted only by the stalls.
  - wen_n = 1 on every gap cycle.
- Start with num_tiles=0: done pulses on the next cycle; no writes issued.
- Reset asserted at g=3 of a T=2 job:
  - Outputs return to reset values immediately; state is IDLE.
  - A new start completes correctly.
- WRITE_OUT_SAT_EN, lane = 40000: wdata lane = 32767 and sat_flag = 1.
  - Without the macro: same stimulus gives lane = 40000 mod 65536 = 0x9C40, and sat_flag = 0.
